// File: rtl/arbitro_mux8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arbitro_mux8                                               |
// | Description : Round-robin arbiter driving the select of an 8-input,      |
// |               32-bit mux; moves bursts of up to RAJADA_MAX beats per     |
// |               grant into a registered output slot with ready handshake.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arbitro_mux8 #(
  parameter int unsigned RAJADA_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  req,
  input  logic [31:0] entrada_mux,
  input  logic        pronto,
  output logic [2:0]  controlador,
  output logic [7:0]  ack,
  output logic [31:0] saida,
  output logic        saida_valida,
  output logic        ocupado
);

  localparam logic [4:0] C_RAJADA = 5'(RAJADA_MAX);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    TRANSFERE = 2'd1,
    ESPERA    = 2'd2
  } estado_t;

  estado_t     r_state;
  estado_t     w_state_nxt;
  logic [2:0]  r_controlador, w_ctrl_nxt;
  logic [2:0]  r_ponteiro,    w_ptr_nxt;
  logic [3:0]  r_contador,    w_cnt_nxt;
  logic [31:0] r_saida,       w_saida_nxt;
  logic        r_saida_valida, w_valid_nxt;
  logic [7:0]  w_ack;
  logic        w_capture;

  logic [2:0]  w_winner;
  logic [2:0]  w_scan_idx;
  logic        w_found;
  logic        w_req_sel;
  logic        w_slot_free;
  logic        w_last;

  // Rotating priority search: first requester at or above the pointer, modulo 8.
  always_comb begin
    w_winner   = 3'd0;
    w_scan_idx = 3'd0;
    w_found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_scan_idx = r_ponteiro + 3'(i);
      if (!w_found && req[w_scan_idx]) begin
        w_winner = w_scan_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_req_sel   = req[r_controlador];
  assign w_slot_free = !r_saida_valida || pronto;
  assign w_last      = ({1'b0, r_contador} + 5'd1) == C_RAJADA;

  // Next-state, datapath next values and the combinational ack pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl_nxt  = r_controlador;
    w_ptr_nxt   = r_ponteiro;
    w_cnt_nxt   = r_contador;
    w_saida_nxt = r_saida;
    w_valid_nxt = r_saida_valida;
    w_ack       = 8'd0;
    w_capture   = 1'b0;

    // Downstream drain; a capture below in the same cycle overrides it.
    if (r_saida_valida && pronto) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      OCIOSO: begin
        if (w_found) begin
          w_ctrl_nxt  = w_winner;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = TRANSFERE;
        end
      end
      TRANSFERE: begin
        if (!w_req_sel) begin
          // Requester gave up early: release without a beat.
          w_ptr_nxt   = r_controlador + 3'd1;
          w_state_nxt = OCIOSO;
        end else if (w_slot_free) begin
          w_capture              = 1'b1;
          w_ack[r_controlador]   = 1'b1;
          w_saida_nxt            = entrada_mux;
          w_valid_nxt            = 1'b1;
          w_cnt_nxt              = r_contador + 4'd1;
          if (w_last) begin
            w_ptr_nxt   = r_controlador + 3'd1;
            w_state_nxt = OCIOSO;
          end
        end else begin
          w_state_nxt = ESPERA;
        end
      end
      ESPERA: begin
        if (pronto) begin
          w_state_nxt = TRANSFERE;
        end
      end
      default: begin
        w_state_nxt = OCIOSO;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= OCIOSO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Select, pointer, beat counter and output slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_controlador  <= 3'd0;
      r_ponteiro     <= 3'd0;
      r_contador     <= 4'd0;
      r_saida        <= 32'd0;
      r_saida_valida <= 1'b0;
    end else begin
      r_controlador  <= w_ctrl_nxt;
      r_ponteiro     <= w_ptr_nxt;
      r_contador     <= w_cnt_nxt;
      r_saida        <= w_saida_nxt;
      r_saida_valida <= w_valid_nxt;
    end
  end

  assign controlador  = r_controlador;
  assign ack          = w_ack;
  assign saida        = r_saida;
  assign saida_valida = r_saida_valida;
  assign ocupado      = (r_state != OCIOSO);

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_arbitro_mux8                                            |
// | Description : Directed self-checking bench for arbitro_mux8              |
// |               (RAJADA_MAX = 4).                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_arbitro_mux8;

  logic        clk;
  logic        reset_n;
  logic [7:0]  req;
  logic [31:0] entrada_mux;
  logic        pronto;
  logic [2:0]  controlador;
  logic [7:0]  ack;
  logic [31:0] saida;
  logic        saida_valida;
  logic        ocupado;

  int n_cmp = 0;
  int n_bad = 0;

  arbitro_mux8 #(.RAJADA_MAX(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .entrada_mux  (entrada_mux),
    .pronto       (pronto),
    .controlador  (controlador),
    .ack          (ack),
    .saida        (saida),
    .saida_valida (saida_valida),
    .ocupado      (ocupado)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    req         = 8'h00;
    entrada_mux = 32'h0;
    pronto      = 1'b0;
    #2;
    chk("rst_ctrl",  {29'd0, controlador}, 32'd0);
    chk("rst_ack",   {24'd0, ack}, 32'd0);
    chk("rst_saida", saida, 32'd0);
    chk("rst_valid", {31'd0, saida_valida}, 32'd0);
    chk("rst_ocup",  {31'd0, ocupado}, 32'd0);

    // ---- single requester, 4-beat burst on input 2 ----
    cyc();
    reset_n = 1'b1; req = 8'h04; pronto = 1'b1;
    settle();
    chk("c0_ack",  {24'd0, ack}, 32'd0);
    chk("c0_ocup", {31'd0, ocupado}, 32'd0);

    cyc(); entrada_mux = 32'hA000_000A; settle();
    chk("s_ctrl",  {29'd0, controlador}, 32'd2);
    chk("s_ocup",  {31'd0, ocupado}, 32'd1);
    chk("s_ack1",  {24'd0, ack}, 32'h04);
    chk("s_val1",  {31'd0, saida_valida}, 32'd0);

    cyc(); entrada_mux = 32'hB000_000B; settle();
    chk("s_ack2",  {24'd0, ack}, 32'h04);
    chk("s_sai_a", saida, 32'hA000_000A);
    chk("s_val2",  {31'd0, saida_valida}, 32'd1);

    cyc(); entrada_mux = 32'hC000_000C; settle();
    chk("s_ack3",  {24'd0, ack}, 32'h04);
    chk("s_sai_b", saida, 32'hB000_000B);

    cyc(); entrada_mux = 32'hD000_000D; settle();
    chk("s_ack4",  {24'd0, ack}, 32'h04);
    chk("s_sai_c", saida, 32'hC000_000C);

    cyc(); req = 8'h00; settle();
    chk("s_idle_ocup", {31'd0, ocupado}, 32'd0);
    chk("s_idle_ack",  {24'd0, ack}, 32'd0);
    chk("s_idle_ctrl", {29'd0, controlador}, 32'd2);
    chk("s_sai_d",     saida, 32'hD000_000D);
    chk("s_idle_val",  {31'd0, saida_valida}, 32'd1);

    cyc(); settle();
    chk("s_drain_val", {31'd0, saida_valida}, 32'd0);
    chk("s_hold_ctrl", {29'd0, controlador}, 32'd2);

    // ---- pointer must be 3: req 2|3 picks 3; requests change mid-grant ----
    req = 8'h0C; settle();
    cyc(); req = 8'h08; entrada_mux = 32'hE000_000E; settle();
    chk("e_ctrl", {29'd0, controlador}, 32'd3);
    chk("e_ack1", {24'd0, ack}, 32'h08);

    cyc(); entrada_mux = 32'hF000_000F; settle();
    chk("e_ack2", {24'd0, ack}, 32'h08);

    cyc(); req = 8'h00; settle();
    chk("e_drop_ack",  {24'd0, ack}, 32'd0);
    chk("e_drop_ocup", {31'd0, ocupado}, 32'd1);
    chk("e_sai_f",     saida, 32'hF000_000F);

    cyc(); settle();
    chk("e_rel_ocup", {31'd0, ocupado}, 32'd0);
    chk("e_rel_val",  {31'd0, saida_valida}, 32'd0);

    // ---- pointer must be 4: req 0|4 picks 4; backpressure ----
    req = 8'h11; settle();
    cyc(); entrada_mux = 32'h1111_0001; settle();
    chk("b_ctrl", {29'd0, controlador}, 32'd4);
    chk("b_ack1", {24'd0, ack}, 32'h10);

    cyc(); pronto = 1'b0; entrada_mux = 32'h1111_0002; settle();
    chk("b_stall_ack", {24'd0, ack}, 32'd0);
    chk("b_sai_g",     saida, 32'h1111_0001);

    cyc(); settle();
    chk("b_wait_ack",  {24'd0, ack}, 32'd0);
    chk("b_wait_ocup", {31'd0, ocupado}, 32'd1);
    chk("b_wait_sai",  saida, 32'h1111_0001);
    chk("b_wait_val",  {31'd0, saida_valida}, 32'd1);

    cyc(); pronto = 1'b1; settle();
    chk("b_resume_ack", {24'd0, ack}, 32'd0);
    chk("b_resume_sai", saida, 32'h1111_0001);

    cyc(); settle();
    chk("b_ack2",  {24'd0, ack}, 32'h10);
    chk("b_val_d", {31'd0, saida_valida}, 32'd0);
    chk("b_ctrl2", {29'd0, controlador}, 32'd4);

    cyc(); entrada_mux = 32'h1111_0003; settle();
    chk("b_ack3",  {24'd0, ack}, 32'h10);
    chk("b_sai_h", saida, 32'h1111_0002);

    cyc(); entrada_mux = 32'h1111_0004; settle();
    chk("b_ack4",  {24'd0, ack}, 32'h10);
    chk("b_sai_i", saida, 32'h1111_0003);

    // ---- pointer 5: req 0|7 round-robin 7,0,7 with idle gaps ----
    cyc(); req = 8'h81; settle();
    chk("b_sai_j",   saida, 32'h1111_0004);
    chk("r_idle0",   {31'd0, ocupado}, 32'd0);

    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < 4; b++) begin
        cyc(); entrada_mux = 32'h7700_0000 + 32'(g * 16 + b); settle();
        chk("r_ctrl", {29'd0, controlador}, (g == 0) ? 32'd7 : 32'd0);
        chk("r_ack",  {24'd0, ack}, (g == 0) ? 32'h80 : 32'h01);
        if (b > 0) chk("r_sai", saida, 32'h7700_0000 + 32'(g * 16 + b - 1));
      end
      cyc(); settle();
      chk("r_gap_ocup", {31'd0, ocupado}, 32'd0);
      chk("r_gap_ack",  {24'd0, ack}, 32'd0);
    end

    // ---- third grant to 7, then reset while waiting in ESPERA ----
    cyc(); entrada_mux = 32'h5555_AAAA; settle();
    chk("x_ctrl", {29'd0, controlador}, 32'd7);
    chk("x_ack",  {24'd0, ack}, 32'h80);

    cyc(); pronto = 1'b0; settle();
    chk("x_stall_ack", {24'd0, ack}, 32'd0);

    cyc(); settle();
    chk("x_wait_val",  {31'd0, saida_valida}, 32'd1);
    chk("x_wait_ocup", {31'd0, ocupado}, 32'd1);
    reset_n = 1'b0; settle();
    chk("x_rst_ctrl",  {29'd0, controlador}, 32'd0);
    chk("x_rst_ack",   {24'd0, ack}, 32'd0);
    chk("x_rst_saida", saida, 32'd0);
    chk("x_rst_val",   {31'd0, saida_valida}, 32'd0);
    chk("x_rst_ocup",  {31'd0, ocupado}, 32'd0);

    cyc(); pronto = 1'b1; reset_n = 1'b1; settle();
    chk("x_rel_ack",  {24'd0, ack}, 32'd0);
    chk("x_rel_ocup", {31'd0, ocupado}, 32'd0);

    cyc(); entrada_mux = 32'h0BAD_CAFE; settle();
    chk("x_new_ctrl", {29'd0, controlador}, 32'd0);
    chk("x_new_ack",  {24'd0, ack}, 32'h01);

    cyc(); req = 8'h00; settle();
    chk("x_new_sai", saida, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
